// File: rtl/axi_slave_mem_pkg.sv
// Purpose : Shared AXI encodings, FSM state types, the burst-control record and
//           the capture-time burst legality check for axi_slave_mem.
// Ports   : none (package).
package axi_slave_mem_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Burst shape captured from AW/AR, shared by both channels and the address generators
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ax_ctl_t;

    // Flags bursts that are illegal for this slave regardless of address
    function automatic logic f_ctl_err(input ax_ctl_t ctl, input logic [2:0] max_size);
        logic wrap_len_ok;
        wrap_len_ok = (ctl.len == 8'd1) || (ctl.len == 8'd3) ||
                      (ctl.len == 8'd7) || (ctl.len == 8'd15);
        return (ctl.burst == BURST_RSVD) || (ctl.size > max_size) ||
               ((ctl.burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi_slave_mem_if.sv
// Purpose : AXI4 AW/W/B/AR/R signal bundle between a master and axi_slave_mem.
// Ports   : none; modport master drives AW/W/AR payloads and BREADY/RREADY,
//           modport slave drives the READYs for AW/W/AR and the B/R payloads.
interface axi_slave_mem_if #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              AWVALID, AWREADY;
    logic [ID_W-1:0]   AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;

    logic              WVALID, WREADY;
    logic [DATA_W-1:0] WDATA;
    logic [STRB_W-1:0] WSTRB;
    logic              WLAST;

    logic              BVALID, BREADY;
    logic [ID_W-1:0]   BID;
    logic [1:0]        BRESP;

    logic              ARVALID, ARREADY;
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;

    logic              RVALID, RREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;

    modport master (
        output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        output WVALID, WDATA, WSTRB, WLAST,
        output BREADY,
        output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        output RREADY,
        input  AWREADY, WREADY, BVALID, BID, BRESP,
        input  ARREADY, RVALID, RID, RDATA, RRESP, RLAST
    );

    modport slave (
        input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
        input  WVALID, WDATA, WSTRB, WLAST,
        input  BREADY,
        input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
        input  RREADY,
        output AWREADY, WREADY, BVALID, BID, BRESP,
        output ARREADY, RVALID, RID, RDATA, RRESP, RLAST
    );

endinterface

// File: rtl/axi_slave_mem_addr_gen.sv
// Purpose : Combinational next-beat byte address for FIXED/INCR/WRAP bursts.
// Ports   : i_addr        current beat byte address
//           i_ctl         captured len/size/burst
//           o_next_addr_c address of the following beat
module axi_slave_mem_addr_gen
    import axi_slave_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  ax_ctl_t           i_ctl,
    output logic [ADDR_W-1:0] o_next_addr_c
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_step_mask;
    logic [ADDR_W-1:0] w_bound_mask;
    logic [ADDR_W-1:0] w_sum;

    // Wrap window is (len+1) beats wide; base is the window-aligned part of the address
    always_comb begin
        w_step        = ADDR_W'(1) << i_ctl.size;
        w_step_mask   = w_step - ADDR_W'(1);
        w_bound_mask  = ((ADDR_W'(i_ctl.len) + ADDR_W'(1)) << i_ctl.size) - ADDR_W'(1);
        w_sum         = i_addr + w_step;
        o_next_addr_c = i_addr;
        case (i_ctl.burst)
            BURST_FIXED: o_next_addr_c = i_addr;
            BURST_INCR:  o_next_addr_c = (i_addr & ~w_step_mask) + w_step;
            BURST_WRAP:  o_next_addr_c = (i_addr & ~w_bound_mask) | (w_sum & w_bound_mask);
            default:     o_next_addr_c = i_addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_mem.sv
// Purpose : AXI4 slave memory: one outstanding write and one outstanding read,
//           handled by independent FSMs over a byte-strobed word array.
// Ports   : ACLK    clock
//           ARESETn async active-low reset (array contents are kept)
//           s_axi   AXI slave modport (AW/W/B/AR/R)
module axi_slave_mem
    import axi_slave_mem_pkg::*;
#(
    parameter int unsigned ID_W      = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    axi_slave_mem_if.slave s_axi
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned BYTE_SH   = $clog2(STRB_W);
    localparam int unsigned WIDX_W    = $clog2(MEM_WORDS);
    localparam int unsigned MEM_BYTES = MEM_WORDS * STRB_W;
    localparam logic [2:0]  MAX_SIZE  = 3'(BYTE_SH);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES);

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    // ---------------- write channel state ----------------
    w_state_e          r_wstate;
    logic              r_awready, r_wready, r_bvalid, r_werr;
    logic [ID_W-1:0]   r_wid, r_bid;
    logic [1:0]        r_bresp;
    logic [ADDR_W-1:0] r_waddr;
    ax_ctl_t           r_wctl;
    logic [7:0]        r_wcnt;

    ax_ctl_t           w_aw_ctl;
    logic [ADDR_W-1:0] w_wnext;
    logic [WIDX_W-1:0] w_widx;
    logic              w_wfire, w_woob, w_wlast_beat, w_werr_nx, w_we;

    assign w_aw_ctl     = '{len: s_axi.AWLEN, size: s_axi.AWSIZE, burst: s_axi.AWBURST};
    assign w_wfire      = (r_wstate == W_DATA) && s_axi.WVALID && r_wready;
    assign w_woob       = r_waddr >= ADDR_LIMIT;
    assign w_wlast_beat = r_wcnt == r_wctl.len;
    // The beat count, not WLAST, ends the burst; a WLAST disagreement only poisons the response
    assign w_werr_nx    = r_werr || w_woob || (s_axi.WLAST != w_wlast_beat);
    assign w_we         = w_wfire && !r_werr && !w_woob;
    assign w_widx       = WIDX_W'(r_waddr >> BYTE_SH);

    axi_slave_mem_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
        .i_addr        (r_waddr),
        .i_ctl         (r_wctl),
        .o_next_addr_c (w_wnext)
    );

    // Write FSM
    always_ff @(posedge ACLK or negedge ARESETn) begin : wr_fsm
        if (!ARESETn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= RESP_OKAY;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_wctl    <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (s_axi.AWVALID && r_awready) begin
                        r_wid     <= s_axi.AWID;
                        r_waddr   <= s_axi.AWADDR;
                        r_wctl    <= w_aw_ctl;
                        r_wcnt    <= '0;
                        r_werr    <= f_ctl_err(w_aw_ctl, MAX_SIZE);
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_wfire) begin
                        r_waddr <= w_wnext;
                        r_wcnt  <= r_wcnt + 8'd1;
                        r_werr  <= w_werr_nx;
                        if (w_wlast_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_wid;
                            r_bresp  <= w_werr_nx ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Array write port; no reset so contents survive ARESETn
    always_ff @(posedge ACLK) begin : mem_write
        if (w_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi.WSTRB[i]) begin
                    r_mem[w_widx][i*8 +: 8] <= s_axi.WDATA[i*8 +: 8];
                end
            end
        end
    end

    // ---------------- read channel state ----------------
    r_state_e          r_rstate;
    logic              r_arready, r_rvalid, r_rlast, r_rerr;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic [ADDR_W-1:0] r_raddr;
    ax_ctl_t           r_rctl;
    logic [7:0]        r_rcnt;

    ax_ctl_t           w_ar_ctl;
    logic              w_ar_err, w_rfire, w_rload_err;
    logic [ADDR_W-1:0] w_rnext, w_rload_addr;
    logic [WIDX_W-1:0] w_ridx;

    assign w_ar_ctl     = '{len: s_axi.ARLEN, size: s_axi.ARSIZE, burst: s_axi.ARBURST};
    assign w_ar_err     = f_ctl_err(w_ar_ctl, MAX_SIZE);
    assign w_rfire      = (r_rstate == R_DATA) && r_rvalid && s_axi.RREADY;
    // Beat being fetched: the AR address on capture, otherwise the following beat
    assign w_rload_addr = (r_rstate == R_IDLE) ? s_axi.ARADDR : w_rnext;
    assign w_rload_err  = ((r_rstate == R_IDLE) ? w_ar_err : r_rerr) || (w_rload_addr >= ADDR_LIMIT);
    assign w_ridx       = WIDX_W'(w_rload_addr >> BYTE_SH);

    axi_slave_mem_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
        .i_addr        (r_raddr),
        .i_ctl         (r_rctl),
        .o_next_addr_c (w_rnext)
    );

    // Read FSM; RDATA is fetched at the edge that accepts the previous beat (or the AR)
    always_ff @(posedge ACLK or negedge ARESETn) begin : rd_fsm
        if (!ARESETn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rerr    <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_raddr   <= '0;
            r_rctl    <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (s_axi.ARVALID && r_arready) begin
                        r_raddr   <= s_axi.ARADDR;
                        r_rctl    <= w_ar_ctl;
                        r_rerr    <= w_ar_err;
                        r_rcnt    <= '0;
                        r_rid     <= s_axi.ARID;
                        r_rlast   <= s_axi.ARLEN == 8'd0;
                        r_rdata   <= w_rload_err ? '0 : r_mem[w_ridx];
                        r_rresp   <= w_rload_err ? RESP_SLVERR : RESP_OKAY;
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_rfire) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_raddr <= w_rnext;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rlast <= 8'(r_rcnt + 8'd1) == r_rctl.len;
                            r_rdata <= w_rload_err ? '0 : r_mem[w_ridx];
                            r_rresp <= w_rload_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.AWREADY = r_awready;
    assign s_axi.WREADY  = r_wready;
    assign s_axi.BVALID  = r_bvalid;
    assign s_axi.BID     = r_bid;
    assign s_axi.BRESP   = r_bresp;
    assign s_axi.ARREADY = r_arready;
    assign s_axi.RVALID  = r_rvalid;
    assign s_axi.RID     = r_rid;
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;
    assign s_axi.RLAST   = r_rlast;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Purpose : Self-checking bench for axi_slave_mem: a table of write/read bursts
//           with hand-computed responses, plus backpressure and mid-burst reset sequences.
// Ports   : none (top-level bench).
module tb_axi_slave_mem;
    import axi_slave_mem_pkg::*;

    localparam int TMO = 100;

    typedef struct packed {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        logic [3:0][31:0] d;      // write data, or expected read data, per beat
        logic [7:0]  early;       // beat carrying WLAST when forced early, 8'hFF = normal
        logic [1:0]  resp;        // expected BRESP / RRESP
    } vec_t;

    logic aclk = 1'b0;
    logic aresetn;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur     = -1;
    vec_t vecs[19];

    always #5 aclk = ~aclk;

    axi_slave_mem_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) ifc ();

    axi_slave_mem #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .MEM_WORDS(1024)) dut (
        .ACLK    (aclk),
        .ARESETn (aresetn),
        .s_axi   (ifc)
    );

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got 0x%0h expected 0x%0h", name, cur, act, exp);
        end
    endtask

    task automatic tmo_chk(input string name, input int t);
        n_tests++;
        if (t >= TMO) begin
            n_fail++;
            $display("FAIL %s (vec %0d): no handshake within %0d cycles", name, cur, TMO);
        end
    endtask

    function automatic logic [49:0] outs();
        return {ifc.AWREADY, ifc.WREADY, ifc.BVALID, ifc.BID, ifc.BRESP, ifc.ARREADY,
                ifc.RVALID, ifc.RID, ifc.RDATA, ifc.RRESP, ifc.RLAST};
    endfunction

    function automatic vec_t mk(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                                input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size,
                                input logic [3:0] strb, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [7:0] early, input logic [1:0] resp);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.strb = strb; v.d = {d3, d2, d1, d0}; v.early = early; v.resp = resp;
        return v;
    endfunction

    task automatic do_write(input vec_t v, input int bready_delay);
        int t;
        ifc.AWVALID = 1'b1; ifc.AWID = v.id; ifc.AWADDR = v.addr;
        ifc.AWLEN = v.len; ifc.AWSIZE = v.size; ifc.AWBURST = v.burst;
        t = 0;
        while (!ifc.AWREADY && t < TMO) begin cyc(); t++; end
        tmo_chk("aw_wait", t);
        cyc();
        ifc.AWVALID = 1'b0;
        for (int b = 0; b <= int'(v.len); b++) begin
            ifc.WVALID = 1'b1;
            ifc.WDATA  = v.d[2'(b)];
            ifc.WSTRB  = v.strb;
            ifc.WLAST  = (v.early != 8'hFF) ? (b == int'(v.early)) : (b == int'(v.len));
            chk("bvalid_before_last", 64'(ifc.BVALID), 64'(0));
            t = 0;
            while (!ifc.WREADY && t < TMO) begin cyc(); t++; end
            tmo_chk("w_wait", t);
            cyc();
        end
        ifc.WVALID = 1'b0;
        ifc.WLAST  = 1'b0;
        t = 0;
        while (!ifc.BVALID && t < TMO) begin cyc(); t++; end
        tmo_chk("b_wait", t);
        for (int k = 0; k < bready_delay; k++) begin
            chk("b_hold_valid", 64'(ifc.BVALID), 64'(1));
            chk("b_hold_id", 64'(ifc.BID), 64'(v.id));
            chk("b_hold_resp", 64'(ifc.BRESP), 64'(v.resp));
            cyc();
        end
        chk("bid", 64'(ifc.BID), 64'(v.id));
        chk("bresp", 64'(ifc.BRESP), 64'(v.resp));
        ifc.BREADY = 1'b1;
        cyc();
        ifc.BREADY = 1'b0;
        chk("b_done", 64'(ifc.BVALID), 64'(0));
    endtask

    task automatic do_read(input vec_t v, input bit toggle);
        int t;
        int b;
        ifc.ARVALID = 1'b1; ifc.ARID = v.id; ifc.ARADDR = v.addr;
        ifc.ARLEN = v.len; ifc.ARSIZE = v.size; ifc.ARBURST = v.burst;
        t = 0;
        while (!ifc.ARREADY && t < TMO) begin cyc(); t++; end
        tmo_chk("ar_wait", t);
        cyc();
        ifc.ARVALID = 1'b0;
        ifc.RREADY  = !toggle;
        b = 0;
        t = 0;
        while (b <= int'(v.len) && t < TMO) begin
            if (ifc.RVALID) begin
                chk("rdata", 64'(ifc.RDATA), 64'(v.d[2'(b)]));
                chk("rresp", 64'(ifc.RRESP), 64'(v.resp));
                chk("rid",   64'(ifc.RID),   64'(v.id));
                chk("rlast", 64'(ifc.RLAST), 64'(b == int'(v.len)));
                if (ifc.RREADY) b++;
            end
            cyc();
            t++;
            if (toggle) ifc.RREADY = !ifc.RREADY;
        end
        tmo_chk("r_wait", t);
        ifc.RREADY = 1'b0;
        chk("r_done", 64'(ifc.RVALID), 64'(0));
    endtask

    initial begin
        aresetn = 1'b0;
        ifc.AWVALID = 0; ifc.AWID = 0; ifc.AWADDR = 0; ifc.AWLEN = 0; ifc.AWSIZE = 0; ifc.AWBURST = 0;
        ifc.WVALID = 0; ifc.WDATA = 0; ifc.WSTRB = 0; ifc.WLAST = 0; ifc.BREADY = 0;
        ifc.ARVALID = 0; ifc.ARID = 0; ifc.ARADDR = 0; ifc.ARLEN = 0; ifc.ARSIZE = 0; ifc.ARBURST = 0;
        ifc.RREADY = 0;

        //              wr id    addr         len  burst       sz strb d0..d3                                              early  resp
        vecs[0]  = mk(1, 4'h3, 32'h10,   8'd3, BURST_INCR, 3'd2, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 8'hFF, RESP_OKAY);
        vecs[1]  = mk(0, 4'h5, 32'h10,   8'd3, BURST_INCR, 3'd2, 4'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 8'hFF, RESP_OKAY);
        vecs[2]  = mk(1, 4'h1, 32'h38,   8'd3, BURST_WRAP, 3'd2, 4'hF, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 8'hFF, RESP_OKAY);
        vecs[3]  = mk(0, 4'h2, 32'h30,   8'd3, BURST_INCR, 3'd2, 4'h0, 32'hB2, 32'hB3, 32'hB0, 32'hB1, 8'hFF, RESP_OKAY);
        vecs[4]  = mk(0, 4'h6, 32'h38,   8'd3, BURST_WRAP, 3'd2, 4'h0, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 8'hFF, RESP_OKAY);
        vecs[5]  = mk(1, 4'h7, 32'h80,   8'd0, BURST_INCR, 3'd2, 4'hF, 32'h12345678, 0, 0, 0, 8'hFF, RESP_OKAY);
        vecs[6]  = mk(1, 4'h8, 32'h80,   8'd0, BURST_INCR, 3'd2, 4'h5, 32'hFFFFFFFF, 0, 0, 0, 8'hFF, RESP_OKAY);
        vecs[7]  = mk(0, 4'h9, 32'h80,   8'd0, BURST_INCR, 3'd2, 4'h0, 32'h12FF56FF, 0, 0, 0, 8'hFF, RESP_OKAY);
        vecs[8]  = mk(1, 4'hA, 32'h0,    8'd0, BURST_INCR, 3'd2, 4'hF, 32'h55AA55AA, 0, 0, 0, 8'hFF, RESP_OKAY);
        vecs[9]  = mk(1, 4'hB, 32'h1000, 8'd0, BURST_INCR, 3'd2, 4'hF, 32'hDEADBEEF, 0, 0, 0, 8'hFF, RESP_SLVERR);
        vecs[10] = mk(0, 4'hC, 32'h0,    8'd0, BURST_INCR, 3'd2, 4'h0, 32'h55AA55AA, 0, 0, 0, 8'hFF, RESP_OKAY);
        vecs[11] = mk(0, 4'hD, 32'h1000, 8'd0, BURST_INCR, 3'd2, 4'h0, 32'h0, 0, 0, 0, 8'hFF, RESP_SLVERR);
        vecs[12] = mk(1, 4'hE, 32'h40,   8'd0, BURST_INCR, 3'd2, 4'hF, 32'h40404040, 0, 0, 0, 8'hFF, RESP_OKAY);
        vecs[13] = mk(1, 4'hF, 32'h40,   8'd0, BURST_RSVD, 3'd2, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 8'hFF, RESP_SLVERR);
        vecs[14] = mk(0, 4'h0, 32'h40,   8'd0, BURST_INCR, 3'd2, 4'h0, 32'h40404040, 0, 0, 0, 8'hFF, RESP_OKAY);
        vecs[15] = mk(1, 4'h1, 32'h60,   8'd3, BURST_INCR, 3'd2, 4'hF, 32'h1, 32'h2, 32'h3, 32'h4, 8'd1, RESP_SLVERR);
        vecs[16] = mk(0, 4'h2, 32'h10,   8'd0, BURST_INCR, 3'd3, 4'h0, 32'h0, 0, 0, 0, 8'hFF, RESP_SLVERR);
        vecs[17] = mk(1, 4'h3, 32'h70,   8'd2, BURST_WRAP, 3'd2, 4'hF, 32'h7, 32'h8, 32'h9, 0, 8'hFF, RESP_SLVERR);
        vecs[18] = mk(0, 4'h4, 32'h60,   8'd0, BURST_INCR, 3'd2, 4'h0, 32'h1, 0, 0, 0, 8'hFF, RESP_OKAY);

        repeat (3) cyc();
        chk("reset_outputs", 64'(outs()), 64'(0));
        aresetn = 1'b1;
        cyc();
        chk("awready_after_reset", 64'(ifc.AWREADY), 64'(1));
        chk("arready_after_reset", 64'(ifc.ARREADY), 64'(1));

        for (int i = 0; i < 19; i++) begin
            cur = i;
            if (vecs[i].wr) do_write(vecs[i], 0);
            else            do_read(vecs[i], 1'b0);
        end

        // Backpressure: BREADY held off, then RREADY toggling over multi-beat reads
        cur = 100;
        do_write(mk(1, 4'h6, 32'h20, 8'd1, BURST_INCR, 3'd2, 4'hF, 32'h20200001, 32'h20200002, 0, 0, 8'hFF, RESP_OKAY), 5);
        cur = 101;
        do_read(mk(0, 4'h7, 32'h20, 8'd1, BURST_INCR, 3'd2, 4'h0, 32'h20200001, 32'h20200002, 0, 0, 8'hFF, RESP_OKAY), 1'b1);
        cur = 102;
        do_read(vecs[1], 1'b1);

        // Reset after 2 of 4 write beats
        cur = 200;
        begin
            int t;
            ifc.AWVALID = 1'b1; ifc.AWID = 4'h9; ifc.AWADDR = 32'hA0;
            ifc.AWLEN = 8'd3; ifc.AWSIZE = 3'd2; ifc.AWBURST = BURST_INCR;
            t = 0;
            while (!ifc.AWREADY && t < TMO) begin cyc(); t++; end
            tmo_chk("rst_aw_wait", t);
            cyc();
            ifc.AWVALID = 1'b0;
            for (int b = 0; b < 2; b++) begin
                ifc.WVALID = 1'b1; ifc.WDATA = 32'hC0 + 32'(b); ifc.WSTRB = 4'hF; ifc.WLAST = 1'b0;
                t = 0;
                while (!ifc.WREADY && t < TMO) begin cyc(); t++; end
                tmo_chk("rst_w_wait", t);
                cyc();
            end
            ifc.WVALID = 1'b0;
            aresetn = 1'b0;
            #1;
            chk("midburst_reset_outputs", 64'(outs()), 64'(0));
            cyc();
            aresetn = 1'b1;
            chk("awready_held_low", 64'(ifc.AWREADY), 64'(0));
            cyc();
            chk("awready_after_midreset", 64'(ifc.AWREADY), 64'(1));
            chk("bvalid_after_midreset", 64'(ifc.BVALID), 64'(0));
        end
        cur = 201;
        do_read(mk(0, 4'h8, 32'hA0, 8'd1, BURST_INCR, 3'd2, 4'h0, 32'hC0, 32'hC1, 0, 0, 8'hFF, RESP_OKAY), 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
